// File: rtl/stage_mem_buf.sv
// rtl/stage_mem_buf.sv - memory stage with in-order load tracking FIFO and writeback
// Optional macro STAGE_MEM_BUF_MISALIGN_EN flags misaligned accesses instead of issuing them.
module stage_mem_buf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_valid,
  input  logic [XLEN-1:0]   mem_pc,
  input  logic [XLEN-1:0]   mem_data0,
  input  logic [XLEN-1:0]   mem_data1,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_extend,
  input  logic [1:0]        mem_width,
  input  logic [4:0]        wb_reg,
  output logic              mem_stall,
  output logic              req,
  input  logic              req_ready,
  output logic [XLEN-1:0]   addr,
  output logic              write,
  output logic [XLEN-1:0]   data_out,
  output logic [XLEN/8-1:0] byte_en,
  input  logic              rsp_valid,
  input  logic [XLEN-1:0]   rsp_data,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_pc,
  output logic [4:0]        wb_reg_r,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_misalign,
  input  logic              wb_stall
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int PW   = $clog2(DEPTH);

  logic [OFFW-1:0] off;
  logic [1:0]      w_eff;
  logic            memop, misalign, full, accept, pop;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q, cmp_idx, idx;
  logic [PW:0]     cnt_q;
  logic            cmp_hit;

  logic [XLEN-1:0] pc_q  [DEPTH];
  logic [XLEN-1:0] res_q [DEPTH];
  logic [4:0]      reg_q [DEPTH];
  logic [OFFW-1:0] off_q [DEPTH];
  logic [1:0]      wid_q [DEPTH];
  logic            ext_q [DEPTH];
  logic [DEPTH-1:0] valid_q, done_q, load_q;

  assign off   = mem_data0[OFFW-1:0];
  assign w_eff = (XLEN == 32 && mem_width == 2'd3) ? 2'd2 : mem_width;
  assign memop = mem_read | mem_write;

`ifdef STAGE_MEM_BUF_MISALIGN_EN
  logic [DEPTH-1:0] mis_q;
  assign misalign    = memop & ((off & OFFW'((1 << w_eff) - 1)) != '0);
  assign wb_misalign = valid_q[rd_ptr_q] & mis_q[rd_ptr_q];
`else
  assign misalign    = 1'b0;
  assign wb_misalign = 1'b0;
`endif

  assign full      = (cnt_q == (PW+1)'(DEPTH));
  assign mem_stall = mem_valid & (full | (memop & ~misalign & ~req_ready));
  assign req       = mem_valid & memop & ~full & ~misalign;
  assign accept    = mem_valid & ~mem_stall;
  assign addr      = {mem_data0[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign write     = mem_write;
  assign data_out  = mem_data1 << {off, 3'b000};
  // Lanes past the top byte are simply dropped; the memory owns any wrap.
  assign byte_en   = NB'(((1 << (1 << w_eff)) - 1) << off);

  assign wb_valid = valid_q[rd_ptr_q] & done_q[rd_ptr_q];
  assign wb_pc    = pc_q[rd_ptr_q];
  assign wb_reg_r = reg_q[rd_ptr_q];
  assign wb_data  = res_q[rd_ptr_q];
  assign pop      = wb_valid & ~wb_stall;

  function automatic logic [XLEN-1:0] load_fmt(input logic [XLEN-1:0] d, input logic [OFFW-1:0] o,
                                               input logic [1:0] w, input logic ext);
    logic [XLEN-1:0] s, mask;
    int bits;
    s    = d >> {o, 3'b000};
    bits = 8 << w;
    if (bits >= XLEN) return s;
    mask = (XLEN'(1) << bits) - 1'b1;
    if (ext && |(s & (mask ^ (mask >> 1)))) return s | ~mask;
    return s & mask;
  endfunction

  // Each response completes the oldest outstanding load, scanning from the head.
  always_comb begin
    cmp_hit = 1'b0;
    cmp_idx = rd_ptr_q;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (!cmp_hit && rsp_valid && valid_q[idx] && !done_q[idx] && load_q[idx]) begin
        cmp_hit = 1'b1;
        cmp_idx = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= '0;
      done_q   <= '0;
`ifdef STAGE_MEM_BUF_MISALIGN_EN
      mis_q    <= '0;
`endif
    end else begin
      if (accept) begin
        valid_q[wr_ptr_q] <= 1'b1;
        done_q[wr_ptr_q]  <= ~(mem_read & ~misalign);
`ifdef STAGE_MEM_BUF_MISALIGN_EN
        mis_q[wr_ptr_q]   <= misalign;
`endif
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (cmp_hit) done_q[cmp_idx] <= 1'b1;
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
      cnt_q <= cnt_q + (PW+1)'(accept) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q[wr_ptr_q]   <= mem_pc;
      reg_q[wr_ptr_q]  <= wb_reg;
      off_q[wr_ptr_q]  <= off;
      wid_q[wr_ptr_q]  <= w_eff;
      ext_q[wr_ptr_q]  <= mem_extend;
      load_q[wr_ptr_q] <= mem_read & ~misalign;
      res_q[wr_ptr_q]  <= mem_data0;
    end
    if (cmp_hit)
      res_q[cmp_idx] <= load_fmt(rsp_data, off_q[cmp_idx], wid_q[cmp_idx], ext_q[cmp_idx]);
  end
endmodule

// File: tb/tb_stage_mem_buf.sv
// tb/tb_stage_mem_buf.sv - directed scoreboard bench for stage_mem_buf (XLEN=32, DEPTH=2)
module tb_stage_mem_buf;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_valid, mem_read, mem_write, mem_extend;
  logic [31:0] mem_pc, mem_data0, mem_data1;
  logic [1:0]  mem_width;
  logic [4:0]  wb_reg;
  logic        mem_stall, req, req_ready, write;
  logic [31:0] addr, data_out;
  logic [3:0]  byte_en;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        wb_valid, wb_misalign, wb_stall;
  logic [31:0] wb_pc, wb_data;
  logic [4:0]  wb_reg_r;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rg;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  stage_mem_buf #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_data0(mem_data0), .mem_data1(mem_data1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_extend(mem_extend),
    .mem_width(mem_width), .wb_reg(wb_reg),
    .mem_stall(mem_stall), .req(req), .req_ready(req_ready), .addr(addr), .write(write),
    .data_out(data_out), .byte_en(byte_en),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_reg_r(wb_reg_r), .wb_data(wb_data),
    .wb_misalign(wb_misalign), .wb_stall(wb_stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [31:0] pc, input logic [31:0] d0, input logic [31:0] d1,
                        input logic rd, input logic wr, input logic ext,
                        input logic [1:0] w, input logic [4:0] rg);
    mem_valid = 1'b1; mem_pc = pc; mem_data0 = d0; mem_data1 = d1;
    mem_read = rd; mem_write = wr; mem_extend = ext; mem_width = w; wb_reg = rg;
  endtask

  task automatic clr_op();
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      pos();
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && wb_valid === 1'b1 && wb_stall === 1'b0) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", {wb_pc, 27'd0, wb_reg_r}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("wb_pc", wb_pc, mon_e.pc);
        check("wb_reg", wb_reg_r, mon_e.rg);
        check("wb_data", wb_data, mon_e.data);
        check("wb_misalign", wb_misalign, mon_e.mis);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; wb_stall = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    mem_pc = '0; mem_data0 = '0; mem_data1 = '0; mem_extend = 1'b0; mem_width = '0; wb_reg = '0;
    clr_op();
    neg();
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_misalign", wb_misalign, 0);
    check("rst_req_idle", req, 0);
    set_op(32'h0, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd0);
    #1;
    check("rst_req_follow", req, 1);
    check("rst_stall_follow", mem_stall, 1);
    clr_op();
    pos();
    reset_n = 1'b1;
    pos();

    // Signed byte load from the top lane
    req_ready = 1'b1;
    set_op(32'h10, 32'h103, 32'h0, 1'b1, 1'b0, 1'b1, 2'd0, 5'd1);
    sb.push_back('{32'h10, 5'd1, 32'hFFFFFF80, 1'b0});
    neg();
    check("a_addr", addr, 32'h100);
    check("a_byte_en", byte_en, 4'b1000);
    check("a_req", req, 1);
    check("a_stall", mem_stall, 0);
    pos(); clr_op();
    neg(); check("a_pending", wb_valid, 0);
    pos(); rsp_valid = 1'b1; rsp_data = 32'h80FFFFFF;
    neg(); check("a_before_edge", wb_valid, 0);
    pos(); rsp_valid = 1'b0;
    neg(); check("a_latency", wb_valid, 1);
    wait_drain("a_drain");

    // Half store held off by req_ready
    req_ready = 1'b0;
    set_op(32'h20, 32'h202, 32'h0000BEEF, 1'b0, 1'b1, 1'b0, 2'd1, 5'd2);
    sb.push_back('{32'h20, 5'd2, 32'h202, 1'b0});
    neg();
    check("b_stall", mem_stall, 1);
    check("b_byte_en", byte_en, 4'b1100);
    check("b_data_out", data_out, 32'hBEEF0000);
    check("b_write", write, 1);
    pos(); req_ready = 1'b1;
    neg(); check("b_stall_rel", mem_stall, 0);
    pos(); clr_op();
    neg(); check("b_wb", wb_valid, 1);
    wait_drain("b_drain");

    // Fill both entries, third op stalls until the first pop
    set_op(32'h30, 32'h300, 32'h0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd3);
    sb.push_back('{32'h30, 5'd3, 32'h11111111, 1'b0});
    pos();
    set_op(32'h34, 32'h304, 32'h0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd4);
    sb.push_back('{32'h34, 5'd4, 32'hCAFE0001, 1'b0});
    pos();
    set_op(32'h38, 32'h77, 32'h0, 1'b0, 1'b0, 1'b0, 2'd2, 5'd5);
    sb.push_back('{32'h38, 5'd5, 32'h77, 1'b0});
    neg(); check("c_full_stall", mem_stall, 1);
    pos(); rsp_valid = 1'b1; rsp_data = 32'h11111111;
    neg(); check("c_full_stall2", mem_stall, 1);
    pos(); rsp_valid = 1'b0;
    neg(); check("c_stall_at_pop", mem_stall, 1);
    pos();
    neg(); check("c_stall_clear", mem_stall, 0);
    pos(); clr_op(); rsp_valid = 1'b1; rsp_data = 32'hCAFE0001;
    pos(); rsp_valid = 1'b0;
    wait_drain("c_drain");

    // ALU result held behind a slow load, and by wb_stall
    set_op(32'h40, 32'h400, 32'h0, 1'b1, 1'b0, 1'b0, 2'd1, 5'd6);
    sb.push_back('{32'h40, 5'd6, 32'h0000ABCD, 1'b0});
    pos();
    set_op(32'h44, 32'h5, 32'h0, 1'b0, 1'b0, 1'b0, 2'd2, 5'd7);
    sb.push_back('{32'h44, 5'd7, 32'h5, 1'b0});
    pos(); clr_op();
    for (int i = 0; i < 3; i++) begin
      neg(); check("d_hold", wb_valid, 0);
      pos();
    end
    wb_stall = 1'b1; rsp_valid = 1'b1; rsp_data = 32'h1234ABCD;
    pos(); rsp_valid = 1'b0;
    neg(); check("d_stalled_pc", wb_pc, 32'h40);
    pos();
    neg(); check("d_stalled_valid", wb_valid, 1);
    pos(); wb_stall = 1'b0;
    wait_drain("d_drain");

    // Stray response with nothing pending
    rsp_valid = 1'b1; rsp_data = 32'h12345678;
    pos(); rsp_valid = 1'b0;
    neg(); check("e_stray_rsp", wb_valid, 0);
    pos();

    // Word access at offset 2
    set_op(32'h60, 32'h6, 32'h0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd8);
`ifdef STAGE_MEM_BUF_MISALIGN_EN
    sb.push_back('{32'h60, 5'd8, 32'h6, 1'b1});
    neg();
    check("f_req", req, 0);
    check("f_stall", mem_stall, 0);
    pos(); clr_op();
    neg(); check("f_wb_misalign", wb_misalign, 1);
`else
    sb.push_back('{32'h60, 5'd8, 32'h0000AAAA, 1'b0});
    neg();
    check("f_req", req, 1);
    check("f_byte_en", byte_en, 4'b1100);
    pos(); clr_op(); rsp_valid = 1'b1; rsp_data = 32'hAAAA5555;
    pos(); rsp_valid = 1'b0;
`endif
    wait_drain("f_drain");

    // Reset with a load in flight
    set_op(32'h70, 32'h700, 32'h0, 1'b1, 1'b0, 1'b0, 2'd2, 5'd9);
    pos(); clr_op();
    neg(); reset_n = 1'b0;
    #1;
    check("g_rst_wb_valid", wb_valid, 0);
    check("g_rst_stall", mem_stall, 0);
    pos(); reset_n = 1'b1; rsp_valid = 1'b1; rsp_data = 32'hDEAD0000;
    neg(); check("g_late_rsp", wb_valid, 0);
    pos(); rsp_valid = 1'b0;
    neg(); check("g_late_rsp2", wb_valid, 0);
    pos();
    set_op(32'h78, 32'h99, 32'h0, 1'b0, 1'b0, 1'b0, 2'd2, 5'd10);
    sb.push_back('{32'h78, 5'd10, 32'h99, 1'b0});
    pos(); clr_op();
    neg(); check("g_next_op", wb_valid, 1);
    wait_drain("g_drain");

    pos();
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
